// File: rtl/vram_arbiter.sv
// Framebuffer RAM arbiter: alternates scan-out read slots with writer/clear write slots
// and re-times VGA sync/enable so they line up with the fetched pixel.
module vram_arbiter #(
  parameter int                FB_W        = 160,
  parameter int                FB_H        = 120,
  parameter int                SCALE_SHIFT = 2,
  parameter int                ADDR_W      = 15,
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = 8'h00
) (
  input  logic              clk_50mhz,
  input  logic              reset_n,
  input  logic              clk_enable_25mhz,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              de_in,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] pixel_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              de_out
);

  localparam int                FB_SIZE   = FB_W * FB_H;
  localparam logic [31:0]       FB_SIZE_U = 32'(FB_SIZE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } clear_state_t;

  clear_state_t      state;
  clear_state_t      state_next;
  logic [ADDR_W-1:0] clear_cnt;
  logic [ADDR_W-1:0] clear_cnt_next;

  logic              visible;
  logic [9:0]        fb_x;
  logic [9:0]        fb_y;
  logic [ADDR_W-1:0] x_ext;
  logic [ADDR_W-1:0] y_ext;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       wr_addr_ext;
  logic              wr_in_range;
  logic              beat;

  assign visible = (hcount < 10'd640) && (vcount < 10'd480);
  assign fb_x    = hcount >> SCALE_SHIFT;
  assign fb_y    = vcount >> SCALE_SHIFT;
  assign x_ext   = ADDR_W'(fb_x);
  assign y_ext   = ADDR_W'(fb_y);

  // The default 160-pixel row stride is two shifts and an add, no multiplier.
  generate
    if (FB_W == 160) begin : g_row_shift_add
      assign row_base = (y_ext << 7) + (y_ext << 5);
    end else begin : g_row_mult
      assign row_base = y_ext * ADDR_W'(FB_W);
    end
  endgenerate

  assign rd_addr     = row_base + x_ext;
  assign wr_addr_ext = 32'(wr_addr);
  assign wr_in_range = wr_addr_ext < FB_SIZE_U;

  assign clear_busy = (state == S_CLEAR);
  assign wr_ready   = ~clk_enable_25mhz & ~clear_busy & reset_n;
  assign beat       = wr_valid & wr_ready;

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      clear_cnt <= '0;
    end else begin
      state     <= state_next;
      clear_cnt <= clear_cnt_next;
    end
  end

  // The clear counter only advances in write slots, in step with the RAM command it feeds.
  always_comb begin
    state_next     = state;
    clear_cnt_next = clear_cnt;
    case (state)
      S_IDLE: begin
        if (clear_req) begin
          state_next     = S_CLEAR;
          clear_cnt_next = '0;
        end
      end
      S_CLEAR: begin
        if (!clk_enable_25mhz) begin
          if (clear_cnt == LAST_ADDR) begin
            state_next = S_IDLE;
          end
          clear_cnt_next = clear_cnt + ADDR_W'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (clk_enable_25mhz) begin
      ram_en <= visible;
      ram_we <= 1'b0;
      if (visible) begin
        ram_addr <= rd_addr;
      end
    end else if (clear_busy) begin
      ram_en    <= 1'b1;
      ram_we    <= 1'b1;
      ram_addr  <= clear_cnt;
      ram_wdata <= CLEAR_COLOR;
    end else if (beat) begin
      ram_en    <= wr_in_range;
      ram_we    <= wr_in_range;
      ram_addr  <= wr_addr;
      ram_wdata <= wr_data;
    end else begin
      ram_en <= 1'b0;
      ram_we <= 1'b0;
    end
  end

  // Capturing de_in on the same tick edge as its pixel keeps all four outputs aligned.
  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      pixel_out <= '0;
      de_out    <= 1'b0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else if (clk_enable_25mhz) begin
      pixel_out <= de_in ? ram_rdata : '0;
      de_out    <= de_in;
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: behavioural RAM, reference framebuffer image and a
// scoreboard of expected scan-out values compared one tick after they are driven.
module tb_vram_arbiter;

  localparam int         FB_W    = 160;
  localparam int         FB_SIZE = 19200;
  localparam logic [7:0] CLR     = 8'hE0;

  typedef struct packed {
    logic [7:0] pix;
    logic       de;
    logic       hs;
    logic       vs;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tick;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        hsync_in;
  logic        vsync_in;
  logic        de_in;
  logic        wr_valid;
  logic        wr_ready;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        clear_req;
  logic        clear_busy;
  logic        ram_en;
  logic        ram_we;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  pixel_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        de_out;

  logic [7:0]  mem     [0:32767];
  logic [7:0]  ref_mem [0:FB_SIZE-1];
  int          we_count;
  exp_t        sb_q[$];
  bit          scan_on;
  int          checks = 0;
  int          errors = 0;

  vram_arbiter #(.CLEAR_COLOR(CLR)) dut (
    .clk_50mhz(clk),
    .reset_n(reset_n),
    .clk_enable_25mhz(tick),
    .hcount(hcount),
    .vcount(vcount),
    .hsync_in(hsync_in),
    .vsync_in(vsync_in),
    .de_in(de_in),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .clear_req(clear_req),
    .clear_busy(clear_busy),
    .ram_en(ram_en),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .pixel_out(pixel_out),
    .hsync_out(hsync_out),
    .vsync_out(vsync_out),
    .de_out(de_out)
  );

  always #10 clk = ~clk;

  function automatic logic [7:0] pat(int i);
    if (i == 161) return 8'hA5;
    return 8'(i * 37 + 11);
  endfunction

  // Synchronous single-port RAM, one-cycle read latency; image reloaded while in reset.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i <= FB_SIZE; i++) mem[i] <= pat(i);
      we_count <= 0;
    end else if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        we_count      <= we_count + 1;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clk cycle: on tick edges check the previous pixel, then clock the timing generator.
  task automatic applyStimulus();
    exp_t e;
    @(negedge clk);
    if (!reset_n) begin
      sb_q.delete();
    end else if (tick) begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput("pixel_out", 16'(pixel_out), 16'(e.pix));
        checkOutput("de_out",    16'(de_out),    16'(e.de));
        checkOutput("hsync_out", 16'(hsync_out), 16'(e.hs));
        checkOutput("vsync_out", 16'(vsync_out), 16'(e.vs));
      end
      de_in    = (hcount < 640) && (vcount < 480);
      hsync_in = !(hcount >= 656 && hcount < 752);
      vsync_in = !(vcount >= 490 && vcount < 492);
      e.de  = de_in;
      e.hs  = hsync_in;
      e.vs  = vsync_in;
      e.pix = 8'h00;
      if (de_in) e.pix = ref_mem[(int'(vcount) / 4) * FB_W + int'(hcount) / 4];
      sb_q.push_back(e);
      if (scan_on) begin
        if (hcount == 10'd799) begin
          hcount = 10'd0;
          vcount = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
        end else begin
          hcount = hcount + 10'd1;
        end
      end
    end
    tick = ~tick;
  endtask

  task automatic run_scan(input int h, input int v, input int n);
    hcount  = 10'(h);
    vcount  = 10'(v);
    scan_on = 1'b1;
    repeat (2 * n) applyStimulus();
    scan_on = 1'b0;
    hcount  = 10'd700;
    vcount  = 10'd500;
  endtask

  task automatic check_reset_values();
    checkOutput("rst_ram_en",     16'(ram_en),     16'd0);
    checkOutput("rst_ram_we",     16'(ram_we),     16'd0);
    checkOutput("rst_ram_addr",   16'(ram_addr),   16'd0);
    checkOutput("rst_ram_wdata",  16'(ram_wdata),  16'd0);
    checkOutput("rst_pixel_out",  16'(pixel_out),  16'd0);
    checkOutput("rst_de_out",     16'(de_out),     16'd0);
    checkOutput("rst_hsync_out",  16'(hsync_out),  16'd1);
    checkOutput("rst_vsync_out",  16'(vsync_out),  16'd1);
    checkOutput("rst_clear_busy", 16'(clear_busy), 16'd0);
    checkOutput("rst_wr_ready",   16'(wr_ready),   16'd0);
  endtask

  initial begin
    int base;
    int exp_beats;
    int busy_cycles;
    int ready_bad;
    int mem_bad;

    reset_n   = 1'b0;
    tick      = 1'b0;
    hcount    = 10'd700;
    vcount    = 10'd500;
    de_in     = 1'b0;
    hsync_in  = 1'b1;
    vsync_in  = 1'b1;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    clear_req = 1'b0;
    scan_on   = 1'b0;
    for (int i = 0; i < FB_SIZE; i++) ref_mem[i] = pat(i);

    repeat (4) applyStimulus();
    #1;
    check_reset_values();
    reset_n = 1'b1;
    repeat (4) applyStimulus();

    $display("[TB] scan-out of preloaded image");
    run_scan(0, 4, 40);
    run_scan(630, 4, 20);
    run_scan(795, 479, 10);

    $display("[TB] writer held valid");
    wr_addr   = 15'h0010;
    wr_data   = 8'h3C;
    wr_valid  = 1'b1;
    base      = we_count;
    exp_beats = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checkOutput("wr_ready_toggle", 16'(wr_ready), 16'(!tick));
      if (!tick) exp_beats++;
      applyStimulus();
    end
    wr_valid = 1'b0;
    repeat (2) applyStimulus();
    checkOutput("we_pulses_per_beat", 16'(we_count - base), 16'(exp_beats));
    ref_mem[16] = 8'h3C;

    if (tick) applyStimulus();
    wr_addr  = 15'd200;
    wr_data  = 8'h5A;
    wr_valid = 1'b1;
    #1;
    checkOutput("wr_ready_slot", 16'(wr_ready), 16'd1);
    applyStimulus();
    wr_valid = 1'b0;
    #1;
    checkOutput("wr_cmd_en",    16'(ram_en),    16'd1);
    checkOutput("wr_cmd_we",    16'(ram_we),    16'd1);
    checkOutput("wr_cmd_addr",  16'(ram_addr),  16'd200);
    checkOutput("wr_cmd_wdata", 16'(ram_wdata), 16'h5A);
    ref_mem[200] = 8'h5A;

    applyStimulus();
    wr_addr  = 15'd19200;
    wr_data  = 8'h77;
    wr_valid = 1'b1;
    #1;
    checkOutput("oor_wr_ready", 16'(wr_ready), 16'd1);
    base = we_count;
    applyStimulus();
    wr_valid = 1'b0;
    #1;
    checkOutput("oor_ram_en", 16'(ram_en), 16'd0);
    checkOutput("oor_ram_we", 16'(ram_we), 16'd0);
    repeat (2) applyStimulus();
    checkOutput("oor_no_write", 16'(we_count - base), 16'd0);
    checkOutput("oor_mem",      16'(mem[19200]),      16'(pat(19200)));

    run_scan(60, 0, 16);
    run_scan(155, 4, 12);
    repeat (4) applyStimulus();

    $display("[TB] full-frame clear with writer pending");
    if (tick) applyStimulus();
    clear_req = 1'b1;
    base      = we_count;
    applyStimulus();
    clear_req = 1'b0;
    wr_addr   = 15'h0020;
    wr_data   = 8'h99;
    wr_valid  = 1'b1;
    busy_cycles = 0;
    ready_bad   = 0;
    for (int k = 0; k < 40000; k++) begin
      #1;
      if (!clear_busy) break;
      busy_cycles++;
      if (wr_ready) ready_bad++;
      applyStimulus();
    end
    checkOutput("clear_busy_cycles", 16'(busy_cycles), 16'(38400));
    checkOutput("wr_ready_in_clear", 16'(ready_bad),   16'd0);
    for (int i = 0; i < FB_SIZE; i++) ref_mem[i] = CLR;
    applyStimulus();
    checkOutput("clear_write_count", 16'(we_count - base), 16'(FB_SIZE));
    #1;
    checkOutput("pending_wr_ready", 16'(wr_ready), 16'd1);
    applyStimulus();
    wr_valid = 1'b0;
    #1;
    checkOutput("pending_we",    16'(ram_we),    16'd1);
    checkOutput("pending_addr",  16'(ram_addr),  16'h20);
    checkOutput("pending_wdata", 16'(ram_wdata), 16'h99);
    ref_mem[32] = 8'h99;
    repeat (2) applyStimulus();
    mem_bad = 0;
    for (int i = 0; i < FB_SIZE; i++) if (mem[i] !== ref_mem[i]) mem_bad++;
    checkOutput("mem_after_clear", 16'(mem_bad), 16'd0);

    $display("[TB] reset during clear");
    if (tick) applyStimulus();
    clear_req = 1'b1;
    applyStimulus();
    clear_req = 1'b0;
    repeat (1000) applyStimulus();
    if (!tick) applyStimulus();
    #1;
    checkOutput("pre_reset_we",   16'(ram_we),     16'd1);
    checkOutput("pre_reset_busy", 16'(clear_busy), 16'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values();
    repeat (3) applyStimulus();
    reset_n = 1'b1;
    base = we_count;
    repeat (200) applyStimulus();
    #1;
    checkOutput("post_reset_busy",   16'(clear_busy),      16'd0);
    checkOutput("post_reset_writes", 16'(we_count - base), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
